// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the rPLL reconfiguration controller.
// Divider selects are stored already encoded for the rPLL dynamic ports.
package pll_ctrl_pkg;

  localparam int DIV_W = 6;

  typedef enum logic [2:0] {
    RESET_HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } pll_state_t;

  // The rPLL dynamic select ports take (64 - divide factor).
  function automatic logic [DIV_W-1:0] rpll_enc(input int unsigned div);
    return DIV_W'((1 << DIV_W) - div);
  endfunction

  // 27 MHz * 28 / 9 = 84 MHz, VCO 672 MHz with output divide 8.
  localparam logic [DIV_W-1:0] PLAN84_IDSEL  = rpll_enc(9);
  localparam logic [DIV_W-1:0] PLAN84_FBDSEL = rpll_enc(28);
  localparam logic [DIV_W-1:0] PLAN84_ODSEL  = rpll_enc(8);

  // 27 MHz * 55 / 6 = 247.5 MHz (nearest to 248), VCO 990 MHz with output divide 4.
  localparam logic [DIV_W-1:0] PLAN248_IDSEL  = rpll_enc(6);
  localparam logic [DIV_W-1:0] PLAN248_FBDSEL = rpll_enc(55);
  localparam logic [DIV_W-1:0] PLAN248_ODSEL  = rpll_enc(4);

endpackage

// File: rtl/pll_reconfig_ctrl_sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into clk.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// rPLL bring-up, lock supervision and divider reconfiguration controller.
// Downstream logic may only use the PLL output clock while clk_en is high.
module pll_reconfig_ctrl #(
  parameter int               DIV_W         = pll_ctrl_pkg::DIV_W,
  parameter int               RST_CYCLES    = 16,
  parameter int               LOCK_TIMEOUT  = 27000,
  parameter int               STABLE_CYCLES = 256,
  parameter int               MAX_RETRIES   = 3,
  parameter logic [DIV_W-1:0] INIT_IDSEL    = '0,
  parameter logic [DIV_W-1:0] INIT_FBDSEL   = '0,
  parameter logic [DIV_W-1:0] INIT_ODSEL    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_idsel,
  input  logic [DIV_W-1:0] cfg_fbdsel,
  input  logic [DIV_W-1:0] cfg_odsel,
  input  logic             fault_clr,
  input  logic             pll_lock,
  output logic             pll_reset,
  output logic [DIV_W-1:0] pll_idsel,
  output logic [DIV_W-1:0] pll_fbdsel,
  output logic [DIV_W-1:0] pll_odsel,
  output logic             clk_en,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       retry_cnt,
  output logic [7:0]       lock_loss_cnt
);
  import pll_ctrl_pkg::*;

  localparam int TMR_MAX = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int STB_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

  pll_state_t       state, state_next;
  logic [TMR_W-1:0] timer, timer_next;
  logic [STB_W-1:0] stable_cnt, stable_next;
  logic [1:0]       retry_next;
  logic [7:0]       loss_next;
  logic             load_sel;
  logic             handshake;
  logic             lock_s;

  sync_2ff #(.WIDTH(1), .RST_VAL(1'b0)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Handshake: a divider set transfers on any cycle where cfg_valid and
  // cfg_ready are both high; cfg_ready depends only on state, never on cfg_valid.
  assign cfg_ready = (state == RUN) || (state == FAULT);
  assign handshake = cfg_valid && cfg_ready;

  always_comb begin
    state_next  = state;
    timer_next  = timer + TMR_W'(1);
    stable_next = stable_cnt;
    retry_next  = retry_cnt;
    loss_next   = lock_loss_cnt;
    load_sel    = 1'b0;
    unique case (state)
      RESET_HOLD: begin
        if (timer == RST_LAST) begin
          state_next = WAIT_LOCK;
          timer_next = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next  = STABLE;
          stable_next = '0;
          timer_next  = '0;
        end else if (timer == TO_LAST) begin
          timer_next = '0;
          if (retry_cnt < RETRY_MAX) begin
            retry_next = retry_cnt + 2'd1;
            state_next = RESET_HOLD;
          end else begin
            state_next = FAULT;
          end
        end
      end
      STABLE: begin
        timer_next = '0;
        if (!lock_s) begin
          state_next = WAIT_LOCK;
        end else if (stable_cnt == STB_LAST) begin
          state_next = RUN;
          retry_next = '0;
        end else begin
          stable_next = stable_cnt + STB_W'(1);
        end
      end
      RUN: begin
        timer_next = '0;
        load_sel   = handshake;
        // A config request and a lock loss on the same cycle share one re-lock.
        if (!lock_s && (lock_loss_cnt != 8'hFF)) loss_next = lock_loss_cnt + 8'd1;
        if (handshake || !lock_s) state_next = RESET_HOLD;
      end
      FAULT: begin
        timer_next = '0;
        load_sel   = handshake;
        if (handshake || fault_clr) begin
          retry_next = '0;
          state_next = RESET_HOLD;
        end
      end
      default: begin
        timer_next = '0;
        state_next = RESET_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RESET_HOLD;
      timer         <= '0;
      stable_cnt    <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_reset     <= 1'b1;
      clk_en        <= 1'b0;
      busy          <= 1'b1;
      fault         <= 1'b0;
      pll_idsel     <= INIT_IDSEL;
      pll_fbdsel    <= INIT_FBDSEL;
      pll_odsel     <= INIT_ODSEL;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      stable_cnt    <= stable_next;
      retry_cnt     <= retry_next;
      lock_loss_cnt <= loss_next;
      // Outputs follow the next state so they line up with the state register.
      pll_reset     <= (state_next == RESET_HOLD) || (state_next == FAULT);
      clk_en        <= (state_next == RUN);
      busy          <= state_next inside {RESET_HOLD, WAIT_LOCK, STABLE};
      fault         <= (state_next == FAULT);
      if (load_sel) begin
        pll_idsel  <= cfg_idsel;
        pll_fbdsel <= cfg_fbdsel;
        pll_odsel  <= cfg_odsel;
      end
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Bench for pll_reconfig_ctrl: segment table, directed corner sequences and
// random stimulus, all compared cycle by cycle against a behavioural model.
module tb_pll_reconfig_ctrl;
  import pll_ctrl_pkg::*;

  localparam int RST_C = 4;
  localparam int TO    = 20;
  localparam int STB   = 8;
  localparam int MAXR  = 2;
  localparam logic [5:0] INIT_ID = 6'h05;
  localparam logic [5:0] INIT_FB = 6'h0A;
  localparam logic [5:0] INIT_OD = 6'h11;
  localparam int VW = 33;

  localparam int PH_HOLD   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAULT  = 4;

  logic       clk = 1'b0;
  logic       rst, cfg_valid, fault_clr, pll_lock;
  logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
  logic       cfg_ready, pll_reset, clk_en, busy, fault;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int total = 0;
  int bad   = 0;
  int run_left = 0;

  int         m_phase, m_age, m_retry, m_loss;
  logic [5:0] m_id, m_fb, m_od;
  logic       m_l1, m_l2;
  logic [VW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(
    .DIV_W(6), .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STB),
    .MAX_RETRIES(MAXR), .INIT_IDSEL(INIT_ID), .INIT_FBDSEL(INIT_FB), .INIT_ODSEL(INIT_OD)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
    .fault_clr(fault_clr), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
    .clk_en(clk_en), .busy(busy), .fault(fault), .retry_cnt(retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {pll_reset, clk_en, busy, fault, cfg_ready, retry_cnt, lock_loss_cnt,
            pll_idsel, pll_fbdsel, pll_odsel};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic pr, ce, bz, ft;
    pr = (m_phase == PH_HOLD) || (m_phase == PH_FAULT);
    ce = (m_phase == PH_RUN);
    bz = (m_phase == PH_HOLD) || (m_phase == PH_WAIT) || (m_phase == PH_STABLE);
    ft = (m_phase == PH_FAULT);
    return {pr, ce, bz, ft, ce | ft, 2'(m_retry), 8'(m_loss), m_id, m_fb, m_od};
  endfunction

  task automatic enter(input int ph);
    m_phase = ph;
    m_age   = 0;
  endtask

  // Model: m_age counts clock edges spent in the current phase; lock is seen two edges late.
  task automatic model_step();
    logic ls;
    bit   hs;
    if (rst) begin
      enter(PH_HOLD);
      m_retry = 0; m_loss = 0;
      m_id = INIT_ID; m_fb = INIT_FB; m_od = INIT_OD;
      m_l1 = 1'b0; m_l2 = 1'b0;
    end else begin
      ls = m_l2; m_l2 = m_l1; m_l1 = pll_lock;
      hs = cfg_valid && (m_phase == PH_RUN || m_phase == PH_FAULT);
      if (hs) begin
        m_id = cfg_idsel; m_fb = cfg_fbdsel; m_od = cfg_odsel;
      end
      case (m_phase)
        PH_HOLD: begin
          m_age++;
          if (m_age == RST_C) enter(PH_WAIT);
        end
        PH_WAIT: begin
          if (ls) enter(PH_STABLE);
          else begin
            m_age++;
            if (m_age == TO) begin
              if (m_retry < MAXR) begin
                m_retry++;
                enter(PH_HOLD);
              end else enter(PH_FAULT);
            end
          end
        end
        PH_STABLE: begin
          if (!ls) enter(PH_WAIT);
          else begin
            m_age++;
            if (m_age == STB) begin
              m_retry = 0;
              enter(PH_RUN);
            end
          end
        end
        PH_RUN: begin
          if (!ls && m_loss < 255) m_loss++;
          if (hs || !ls) enter(PH_HOLD);
        end
        default: begin
          if (hs || fault_clr) begin
            m_retry = 0;
            enter(PH_HOLD);
          end
        end
      endcase
    end
    exp_q.push_back(model_vec());
  endtask

  task automatic tick();
    logic [VW-1:0] e;
    @(posedge clk);
    model_step();
    @(negedge clk);
    e = exp_q.pop_front();
    check("outputs", 64'(dut_vec()), 64'(e));
  endtask

  task automatic go_run(input string name);
    int n = 0;
    pll_lock = 1'b1;
    while (!clk_en && n < 200) begin
      tick();
      n++;
    end
    check({name, "_run"}, 64'(clk_en), 64'(1));
  endtask

  task automatic wait_model(input int ph, input int age, input string name);
    int n = 0;
    while (!(m_phase == ph && m_age == age) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_reach"}, 64'(n < 200), 64'(1));
  endtask

  typedef struct {
    bit rst; bit lock; bit fclr; int n;
    bit e_rst; bit e_ce; bit e_busy; bit e_fault; int e_retry; int e_loss;
  } vec_t;

  vec_t tbl[23];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_loss;
    rst = 1'b1; cfg_valid = 1'b0; fault_clr = 1'b0; pll_lock = 1'b0;
    cfg_idsel = '0; cfg_fbdsel = '0; cfg_odsel = '0;

    // {rst, lock, fault_clr, cycles, pll_reset, clk_en, busy, fault, retry, loss}
    tbl = '{
      '{1, 0, 0,  2, 1, 0, 1, 0, 0, 0},
      '{0, 0, 0,  3, 1, 0, 1, 0, 0, 0},
      '{0, 0, 0,  1, 0, 0, 1, 0, 0, 0},
      '{0, 0, 0,  2, 0, 0, 1, 0, 0, 0},
      '{0, 1, 0, 10, 0, 0, 1, 0, 0, 0},
      '{0, 1, 0,  1, 0, 1, 0, 0, 0, 0},
      '{0, 0, 0,  1, 0, 1, 0, 0, 0, 0},
      '{0, 1, 0,  1, 0, 1, 0, 0, 0, 0},
      '{0, 1, 0,  1, 1, 0, 1, 0, 0, 1},
      '{0, 1, 0,  3, 1, 0, 1, 0, 0, 1},
      '{0, 1, 0,  1, 0, 0, 1, 0, 0, 1},
      '{0, 1, 0,  8, 0, 0, 1, 0, 0, 1},
      '{0, 1, 0,  1, 0, 1, 0, 0, 0, 1},
      '{0, 0, 0,  3, 1, 0, 1, 0, 0, 2},
      '{0, 0, 0, 23, 0, 0, 1, 0, 0, 2},
      '{0, 0, 0,  1, 1, 0, 1, 0, 1, 2},
      '{0, 0, 0, 23, 0, 0, 1, 0, 1, 2},
      '{0, 0, 0,  1, 1, 0, 1, 0, 2, 2},
      '{0, 0, 0, 23, 0, 0, 1, 0, 2, 2},
      '{0, 0, 0,  1, 1, 0, 0, 1, 2, 2},
      '{0, 0, 0,  5, 1, 0, 0, 1, 2, 2},
      '{0, 0, 1,  1, 1, 0, 1, 0, 0, 2},
      '{0, 1, 0,  4, 0, 0, 1, 0, 0, 2}
    };

    foreach (tbl[i]) begin
      rst = tbl[i].rst; pll_lock = tbl[i].lock; fault_clr = tbl[i].fclr;
      repeat (tbl[i].n) tick();
      check($sformatf("row%0d", i),
            64'({pll_reset, clk_en, busy, fault, retry_cnt, lock_loss_cnt}),
            64'({tbl[i].e_rst, tbl[i].e_ce, tbl[i].e_busy, tbl[i].e_fault,
                 2'(tbl[i].e_retry), 8'(tbl[i].e_loss)}));
    end
    fault_clr = 1'b0;

    // Reconfiguration from RUN in a single handshake cycle.
    go_run("t4");
    check("t4_ready", 64'(cfg_ready), 64'(1));
    cfg_idsel = PLAN84_IDSEL; cfg_fbdsel = PLAN84_FBDSEL; cfg_odsel = PLAN84_ODSEL;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_idsel = 6'h2B; cfg_fbdsel = 6'h15; cfg_odsel = 6'h0E;
    check("t4_sel", 64'({pll_idsel, pll_fbdsel, pll_odsel}), 64'({6'h37, 6'h24, 6'h38}));
    check("t4_state", 64'({pll_reset, clk_en, cfg_ready}), 64'(3'b100));

    // One-cycle lock glitch at stable count 5 restarts the full stable window.
    wait_model(PH_STABLE, 5, "t5");
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    n = 1;
    while (!clk_en && n < 100) begin
      tick();
      n++;
    end
    check("t5_relock_cycles", 64'(n), 64'(12));

    // Config request and lock loss observed on the same RUN cycle.
    exp_loss = m_loss + 1;
    pll_lock = 1'b0;
    tick();
    tick();
    cfg_idsel = PLAN248_IDSEL; cfg_fbdsel = PLAN248_FBDSEL; cfg_odsel = PLAN248_ODSEL;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("t6_sel", 64'({pll_idsel, pll_fbdsel, pll_odsel}), 64'({6'h3A, 6'h09, 6'h3C}));
    check("t6_loss", 64'(lock_loss_cnt), 64'(8'(exp_loss)));
    n = 0;
    while (pll_reset && n < 50) begin
      n++;
      tick();
    end
    check("t6_hold_len", 64'(n), 64'(RST_C));

    // Reset in the middle of WAIT_LOCK.
    wait_model(PH_WAIT, 5, "t6b");
    rst = 1'b1;
    tick();
    check("t6b_reset", 64'(dut_vec()),
          64'({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, INIT_ID, INIT_FB, INIT_OD}));
    rst = 1'b0;

    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        pll_lock = ($urandom_range(0, 3) != 0);
        run_left = pll_lock ? $urandom_range(1, 60) : $urandom_range(1, 90);
      end
      run_left--;
      cfg_valid  = ($urandom_range(0, 7) == 0);
      cfg_idsel  = 6'($urandom);
      cfg_fbdsel = 6'($urandom);
      cfg_odsel  = 6'($urandom);
      fault_clr  = ($urandom_range(0, 15) == 0);
      rst        = ($urandom_range(0, 999) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_reconfig_ctrl.md
Name: pll_reconfig_ctrl

Overview:
Sequences the Gowin rPLL from power-up through lock. Supervises lock during operation, re-locking on loss. Owns the PLL's dynamic divider selects (IDSEL/FBDSEL/ODSEL) and applies new divider sets on request via a valid/ready handshake. Runs on the 27 MHz crystal clock, sits beside the rPLL instance, and gates downstream use of the PLL output through clk_en.

Parameters:
DIV_W, 6, width of each divider select
RST_CYCLES, 16, cycles pll_reset is held high per attempt
LOCK_TIMEOUT, 27000, cycles allowed in WAIT_LOCK (1 ms @ 27 MHz)
STABLE_CYCLES, 256, consecutive synced-lock cycles required before RUN
MAX_RETRIES, 3, relock attempts after the first before FAULT
INIT_IDSEL, 6'd0, pll_idsel value after reset
INIT_FBDSEL, 6'd0, pll_fbdsel value after reset
INIT_ODSEL, 6'd0, pll_odsel value after reset

Ports:
clk  in  1  27 MHz crystal clock
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  new divider set offered
cfg_ready  out  1  controller accepts a divider set this cycle
cfg_idsel  in  DIV_W  requested IDSEL, already in rPLL encoding
cfg_fbdsel  in  DIV_W  requested FBDSEL
cfg_odsel  in  DIV_W  requested ODSEL
fault_clr  in  1  one-cycle pulse; leaves FAULT
pll_lock  in  1  rPLL LOCK; asynchronous
pll_reset  out  1  to rPLL RESET
pll_idsel  out  DIV_W  to rPLL IDSEL
pll_fbdsel  out  DIV_W  to rPLL FBDSEL
pll_odsel  out  DIV_W  to rPLL ODSEL
clk_en  out  1  PLL clock valid for downstream use
busy  out  1  high in RESET_HOLD, WAIT_LOCK and STABLE
fault  out  1  high in FAULT
retry_cnt  out  2  attempts used in the current lock sequence
lock_loss_cnt  out  8  lock losses seen in RUN; saturates at 255

Behaviour:
- Interface fixed: one clock (clk); reset rst is synchronous and active-high.
- All outputs are registered except cfg_ready, which is combinational: (state==RUN || state==FAULT).
- On rst: state=RESET_HOLD, pll_reset=1, pll_*sel=INIT_*, clk_en=0, fault=0, busy=1, retry_cnt=0, lock_loss_cnt=0, counters=0. This applies mid-operation too, and discards any in-flight request.
- pll_lock passes through a 2-flop synchronizer giving lock_s; allow 2 cycles of latency.
- RESET_HOLD:
  - pll_reset=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
  - pll_reset drops on the WAIT_LOCK entry cycle; the timer clears.
- WAIT_LOCK:
  - lock_s=1: go to STABLE, stable counter=0.
  - Timer reaches LOCK_TIMEOUT-1 with lock_s=0: if retry_cnt<MAX_RETRIES, retry_cnt++ and go to RESET_HOLD; else go to FAULT.
- STABLE:
  - Count consecutive lock_s=1 cycles.
  - lock_s=0: go back to WAIT_LOCK with the timer cleared; retry_cnt is unchanged.
  - After STABLE_CYCLES consecutive cycles: go to RUN, clk_en=1 on the first RUN cycle, retry_cnt=0.
- RUN:
  - cfg_valid&&cfg_ready: latch cfg_* into pll_*sel, clk_en=0 next cycle, go to RESET_HOLD.
  - lock_s=0: lock_loss_cnt++ (saturating), clk_en=0, go to RESET_HOLD.
  - Both in the same cycle: the config is accepted and latched, lock_loss_cnt increments, and a single RESET_HOLD entry occurs.
- FAULT:
  - pll_reset=1, clk_en=0, fault=1.
  - fault_clr: retry_cnt=0, go to RESET_HOLD.
  - A cfg handshake also latches the new selects, clears retry_cnt and goes to RESET_HOLD.
  - Both in the same cycle: behaves as the cfg handshake.
- pll_*sel change only on rst or on an accepted handshake. They are stable for the whole pll_reset window, because selects are latched before RESET_HOLD entry.
- Counter widths: sized with $clog2 of each parameter.
- clk_en is never 1 outside RUN.

Decomposition:
- Shared package pll_ctrl_pkg holds:
  - state encoding (RESET_HOLD, WAIT_LOCK, STABLE, RUN, FAULT);
  - default divider-select constants for the 84 MHz and 248 MHz plans, with rPLL encoding applied;
  - the DIV_W constant.
- One sub-module: sync_2ff, a generic 2-flop synchronizer used for pll_lock.

Test Plan:
All scenarios use bench parameters RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Release rst; raise pll_lock 3 cycles after pll_reset falls -> pll_reset high exactly 4 cycles; clk_en=1 at 2 (sync) + 8 (stable) cycles after lock rises; retry_cnt=0; busy=0.
2. In RUN, drop pll_lock for 1 cycle -> clk_en=0 within 3 cycles; lock_loss_cnt 0→1; pll_reset reasserted for 4 cycles; relock returns to RUN.
3. Hold pll_lock=0 -> three attempts each time out after 20 cycles; retry_cnt goes 1 then 2; then fault=1 with pll_reset=1. Pulse fault_clr -> retry_cnt=0, RESET_HOLD entered.
4. In RUN, present cfg_idsel=6'h37, cfg_fbdsel=6'h24, cfg_odsel=6'h38 with cfg_valid -> handshake completes in 1 cycle; pll_*sel equal those values before pll_reset rises; cfg_ready=0 until RUN is re-entered.
5. Toggle pll_lock low at stable count 5 -> returns to WAIT_LOCK; clk_en stays 0; retry_cnt unchanged; a full 8 consecutive cycles is required afterwards.
6. Same-cycle cfg_valid and lock loss in RUN -> new selects latched, lock_loss_cnt+1, single RESET_HOLD. Also: assert rst mid-WAIT_LOCK -> all outputs return to reset values next cycle, pll_*sel=INIT_*.
